// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives a 1-cycle-latency IMEM and
// buffers returned words in a 2-entry queue. FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_ctrl #(
    parameter int          IMEM_DEPTH      = 2048,
    parameter int          IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
    parameter int          IMEM_DATA_WIDTH = 32,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [IMEM_DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                       i_redir_valid,
    input  logic [63:0]                i_redir_pc,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [IMEM_DATA_WIDTH-1:0] o_inst,
    output logic [63:0]                o_pc,
    output logic [63:0]                o_npc,
    output logic                       o_exc_misaligned
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]                o_perf_fetched,
    output logic [63:0]                o_perf_stall
`endif
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_EXC = 1'b1} state_t;

    typedef struct packed {
        logic                       vld;
        logic                       exc;
        logic [IMEM_DATA_WIDTH-1:0] inst;
        logic [63:0]                pc;
        logic [63:0]                npc;
    } entry_t;

    state_t      state_r;
    logic [63:0] pc_r;
    logic [63:0] tag_pc_r;
    logic        inflight_r;
    entry_t      q_r     [2];
    entry_t      q_nxt_s [2];
    entry_t      ret_s;
    entry_t      exc_s;
    logic        pop_s;
    logic        issue_s;
    logic        misalign_s;
    logic [1:0]  cnt_s;
    logic [1:0]  slot_s;
    logic [2:0]  occ_s;

    // Slot 0 is always the queue head, so outputs come straight from registers.
    assign o_imem_addr      = pc_r[IMEM_ADDR_WIDTH+1:2];
    assign o_valid          = q_r[0].vld;
    assign o_inst           = q_r[0].inst;
    assign o_pc             = q_r[0].pc;
    assign o_npc            = q_r[0].npc;
    assign o_exc_misaligned = q_r[0].exc;

    // Issue decision: only fetch when the word is guaranteed a queue slot on return.
    always_comb begin
        pop_s      = q_r[0].vld & i_ready;
        cnt_s      = {1'b0, q_r[0].vld} + {1'b0, q_r[1].vld};
        occ_s      = {1'b0, cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        slot_s     = cnt_s - {1'b0, pop_s};
        misalign_s = (i_redir_pc[1:0] != 2'b00);
        if ((state_r == ST_RUN) && (occ_s < 3'd2) && !i_redir_valid) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Entry built from the returning memory word and the misaligned-target entry.
    always_comb begin
        ret_s      = '0;
        ret_s.vld  = 1'b1;
        ret_s.exc  = 1'b0;
        ret_s.inst = i_imem_rdata;
        ret_s.pc   = tag_pc_r;
        ret_s.npc  = tag_pc_r + 64'd4;
        exc_s      = '0;
        exc_s.vld  = 1'b1;
        exc_s.exc  = 1'b1;
        exc_s.pc   = i_redir_pc;
        exc_s.npc  = i_redir_pc + 64'd4;
    end

    // Queue next state: pop shifts slot 1 forward, then the returning word fills the first free slot.
    always_comb begin
        if (pop_s) begin
            q_nxt_s[0] = q_r[1];
            q_nxt_s[1] = '0;
        end else begin
            q_nxt_s[0] = q_r[0];
            q_nxt_s[1] = q_r[1];
        end
        case ({inflight_r, slot_s})
            3'b100:  q_nxt_s[0] = ret_s;
            3'b101:  q_nxt_s[1] = ret_s;
            default: ;
        endcase
    end

    // Fetch FSM, PC, in-flight tracking and queue storage; a redirect overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            tag_pc_r   <= 64'h0;
            inflight_r <= 1'b0;
            q_r[0]     <= '0;
            q_r[1]     <= '0;
        end else if (i_redir_valid) begin
            inflight_r <= 1'b0;
            q_r[1]     <= '0;
            if (misalign_s) begin
                state_r <= ST_EXC;
                q_r[0]  <= exc_s;
            end else begin
                state_r <= ST_RUN;
                pc_r    <= i_redir_pc;
                q_r[0]  <= '0;
            end
        end else begin
            q_r[0]     <= q_nxt_s[0];
            q_r[1]     <= q_nxt_s[1];
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r     <= pc_r + 64'd4;
                tag_pc_r <= pc_r;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of delivered instructions and back-pressured cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_fetched <= 64'd0;
            o_perf_stall   <= 64'd0;
        end else begin
            if (pop_s && !q_r[0].exc && (o_perf_fetched != {64{1'b1}})) begin
                o_perf_fetched <= o_perf_fetched + 64'd1;
            end
            if (q_r[0].vld && !i_ready && (o_perf_stall != {64{1'b1}})) begin
                o_perf_stall <= o_perf_stall + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random ready/redirect traffic,
// scored against an expected-instruction stream rebuilt from each redirect target.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        i_redir_valid;
    logic [63:0] i_redir_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [63:0] o_pc;
    logic [63:0] o_npc;
    logic        o_exc;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall;
`endif

    fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .i_redir_valid    (i_redir_valid),
        .i_redir_pc       (i_redir_pc),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_inst           (o_inst),
        .o_pc             (o_pc),
        .o_npc            (o_npc),
        .o_exc_misaligned (o_exc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched   (perf_fetched),
        .o_perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: word k holds 32'h13 + k.
    always @(posedge clk) imem_rdata <= 32'h13 + {21'd0, imem_addr};

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    exp_t   exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     popped      = 0;
    longint model_fetched = 0;
    longint model_stall   = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return 32'h13 + 32'((pc >> 2) % 64'd2048);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected delivery after a redirect/reset to tgt: sequential PCs, or a single exception entry.
    task automatic flush_push(input logic [63:0] tgt);
        exp_q.delete();
        if (tgt[1:0] != 2'b00) begin
            exp_q.push_back('{tgt, tgt + 64'd4, 32'd0, 1'b1});
        end else begin
            for (int i = 0; i < 128; i++) begin
                logic [63:0] p;
                p = tgt + 64'(4 * i);
                exp_q.push_back('{p, p + 64'd4, mem_word(p), 1'b0});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] tgt);
        i_redir_valid = 1'b1;
        i_redir_pc    = tgt;
        step();
        i_redir_valid = 1'b0;
        flush_push(tgt);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!o_valid && n < 10) begin
            step();
            n++;
        end
        if (!o_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: o_valid still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Monitor: scores every handshake and checks head stability under back-pressure.
    logic        hold_vld = 1'b0;
    logic [63:0] hold_pc;
    logic [31:0] hold_inst;
    always @(negedge clk) begin
        if (rst) begin
            hold_vld      = 1'b0;
            model_fetched = 0;
            model_stall   = 0;
        end else begin
            if (hold_vld) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_pc", o_pc, hold_pc);
                chk("hold_inst", 64'(o_inst), 64'(hold_inst));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got pc %h, expected no output", o_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", o_pc, e.pc);
                    chk("out_npc", o_npc, e.npc);
                    chk("out_inst", 64'(o_inst), 64'(e.inst));
                    chk("out_exc", 64'(o_exc), 64'(e.exc));
                    popped++;
                    if (!e.exc) model_fetched++;
                end
            end
            if (o_valid && !i_ready) model_stall++;
            hold_vld  = o_valid && !i_ready && !i_redir_valid;
            hold_pc   = o_pc;
            hold_inst = o_inst;
        end
    end

    initial begin
        logic [10:0] addr_hold;
        logic [63:0] tgt;
        int          since;
        rst           = 1'b1;
        i_ready       = 1'b1;
        i_redir_valid = 1'b0;
        i_redir_pc    = 64'd0;
        flush_push(64'd0);
        repeat (3) step();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_npc", o_npc, 64'd0);
        chk("rst_inst", 64'(o_inst), 64'd0);
        chk("rst_exc", 64'(o_exc), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);

        // Release: addresses 0,1,2 and first valid two cycles later with pc 0.
        rst = 1'b0;
        chk("c0_addr", 64'(imem_addr), 64'd0);
        chk("c0_valid", 64'(o_valid), 64'd0);
        step();
        chk("c1_addr", 64'(imem_addr), 64'd1);
        chk("c1_valid", 64'(o_valid), 64'd0);
        step();
        chk("c2_addr", 64'(imem_addr), 64'd2);
        chk("c2_valid", 64'(o_valid), 64'd1);
        chk("c2_pc", o_pc, 64'd0);
        repeat (15) begin
            step();
            chk("stream_valid", 64'(o_valid), 64'd1);
        end

        // Five stall cycles: no further address issue, head held.
        i_ready   = 1'b0;
        addr_hold = imem_addr;
        repeat (5) begin
            step();
            chk("stall_addr", 64'(imem_addr), 64'(addr_hold));
            chk("stall_valid", 64'(o_valid), 64'd1);
        end
        i_ready = 1'b1;
        repeat (5) step();

        // Redirect while the queue is full.
        i_ready = 1'b0;
        repeat (3) step();
        redirect(64'h100);
        chk("redir_valid_n1", 64'(o_valid), 64'd0);
        chk("redir_addr_n1", 64'(imem_addr), 64'd64);
        i_ready = 1'b1;
        wait_valid("redir_100");
        chk("redir_pc", o_pc, 64'h100);
        repeat (6) step();

        // Misaligned target: single exception entry, then silence.
        redirect(64'h102);
        chk("exc_valid", 64'(o_valid), 64'd1);
        chk("exc_flag", 64'(o_exc), 64'd1);
        chk("exc_pc", o_pc, 64'h102);
        chk("exc_npc", o_npc, 64'h106);
        chk("exc_inst", 64'(o_inst), 64'd0);
        step();
        repeat (10) begin
            chk("exc_quiet", 64'(o_valid), 64'd0);
            step();
        end
        redirect(64'h200);
        wait_valid("redir_200");
        chk("resume_pc", o_pc, 64'h200);
        repeat (8) step();

        // Redirect coincident with a pop.
        chk("pop_pre_valid", 64'(o_valid), 64'd1);
        redirect(64'h300);
        chk("pop_redir_valid", 64'(o_valid), 64'd0);
        wait_valid("redir_300");
        repeat (5) step();

        // Back-to-back redirects; the second one wraps the PC around 2^64.
        redirect(64'h500);
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        wait_valid("redir_wrap");
        chk("wrap_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) step();

        // Asynchronous reset in the middle of a stall.
        i_ready = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_pc", o_pc, 64'd0);
        chk("arst_npc", o_npc, 64'd0);
        chk("arst_inst", 64'(o_inst), 64'd0);
        chk("arst_addr", 64'(imem_addr), 64'd0);
        flush_push(64'd0);
        step();
        step();
        rst     = 1'b0;
        i_ready = 1'b1;
        wait_valid("post_rst");
        chk("post_rst_pc", o_pc, 64'd0);

        // Random back-pressure and redirects.
        since = 0;
        for (int i = 0; i < 400; i++) begin
            i_ready = ($urandom_range(3) != 0);
            if ($urandom_range(24) == 0 || since > 50) begin
                tgt = {$urandom, $urandom};
                if ($urandom_range(3) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
                else tgt[1:0] = 2'b00;
                redirect(tgt);
                since = 0;
            end else begin
                step();
                since++;
            end
        end

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 64'(model_fetched));
        chk("perf_stall", perf_stall, 64'(model_stall));
`endif
        chk("progress", 64'(popped > 150), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
